fpioa_cfg_seq: RTL
==================

# fpioa_cfg_seq

Boot-time configuration sequencer and bus arbiter for the FPIOA register port. After reset it writes a parameter-defined default pin map into all FPIOA output-select and input-select registers. It then hands the FPIOA write/read port to the CPU bus. A `reload_i` pulse from system control re-applies the default map at any time after the first load. It sits between the peripheral bus decoder and the FPIOA register interface.

## Interface
- `DEF_OT`, default 224'h0: packed default output selects. Entry k (FPIOA pin k, k=0..31) is `DEF_OT[7k+6:7k]`.
- `DEF_IN`, default 640'h0: packed default input selects. Entry k (peripheral input k, k=0..127) is `DEF_IN[5k+4:5k]`.
- `clk`, in, 1: system clock; the only clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `reload_i`, in, 1: single-cycle request to re-apply the default map.
- `busy_o`, out, 1: load sequence in progress.
- `done_o`, out, 1: at least one load has completed and the block is idle.
- `cpu_waddr_i`, in, 8: CPU write address.
- `cpu_data_i`, in, 32: CPU write data.
- `cpu_sel_i`, in, 4: CPU byte-lane enables.
- `cpu_we_i`, in, 1: CPU write strobe.
- `cpu_raddr_i`, in, 8: CPU read address.
- `cpu_rd_i`, in, 1: CPU read strobe.
- `cpu_ready_o`, out, 1: CPU access accepted this cycle.
- `cpu_data_o`, out, 32: read data, wired straight from `fpioa_data_i`.
- `fpioa_waddr_o`, out, 8: FPIOA write address.
- `fpioa_data_o`, out, 32: FPIOA write data.
- `fpioa_sel_o`, out, 4: FPIOA byte-lane enables.
- `fpioa_we_o`, out, 1: FPIOA write strobe.
- `fpioa_raddr_o`, out, 8: FPIOA read address.
- `fpioa_rd_o`, out, 1: FPIOA read strobe.
- `fpioa_data_i`, in, 32: FPIOA registered read data.

## Operation
- States: START, LOAD_OT, LOAD_IN, IDLE. Word counter `cnt` is 5 bits wide.
- Reset state is START with `cnt`=0 and `loaded`=0.
- START: no write is issued. Next state is LOAD_OT with `cnt`=0.
- LOAD_OT issues one write per cycle:
  - `fpioa_waddr_o` = 8'h00 + 4·cnt.
  - `fpioa_sel_o` = 4'hF.
  - `fpioa_data_o` byte j = {1'b0, `DEF_OT` entry 4·cnt+j}, for j=0..3.
  - At cnt=7 it moves to LOAD_IN with cnt=0; otherwise cnt+1.
- LOAD_IN issues one write per cycle:
  - `fpioa_waddr_o` = 8'h80 + 4·cnt.
  - `fpioa_data_o` byte j = {3'b0, `DEF_IN` entry 4·cnt+j}.
  - At cnt=31 it moves to IDLE and sets `loaded`=1; otherwise cnt+1.
- Outside IDLE:
  - `fpioa_we_o`=1 in LOAD_OT and LOAD_IN, 0 in START.
  - `fpioa_rd_o`=0 and `cpu_ready_o`=0.
  - CPU strobes are not forwarded. The CPU master holds its request until it sees `cpu_ready_o`=1.
- In IDLE:
  - `cpu_ready_o`=1.
  - All `fpioa_*` outputs equal the corresponding `cpu_*` inputs combinationally.
- `reload_i` in IDLE: next state is START. `loaded` stays at 1, but `done_o` drops because it is gated by IDLE.
- `reload_i` outside IDLE is ignored and not queued.
- `busy_o` = (state != IDLE). `done_o` = (state == IDLE) & `loaded`.

## Timing
- Reset values:
  - `busy_o`=1, `done_o`=0, `cpu_ready_o`=0.
  - `fpioa_we_o`=0, `fpioa_rd_o`=0.
  - `fpioa_sel_o`, `fpioa_waddr_o` and `fpioa_data_o` are all 0.
- Full load is 1 + 8 + 32 = 41 cycles from the first rising edge after reset release to IDLE. FPIOA writes occur on cycles 2..41.
- `cpu_ready_o` rises on cycle 42.
- Write pass-through has zero latency. Read data appears on `cpu_data_o` one cycle after `cpu_rd_i`, matching the FPIOA registered read.
- `reload_i` in the same IDLE cycle as `cpu_we_i`: the CPU write is forwarded in that cycle, and START begins next cycle. The default load then overwrites the CPU write.
- `rst_n` asserted mid-load: the block returns immediately to START with `cnt`=0 and `loaded`=0, and the sequence restarts from entry 0 after release.
- No wrap-around beyond cnt=31. The counter is reloaded to 0 on every state entry.

## Test plan
- Reset release, `DEF_OT` entries 0=7 and 1=32, others 0 -> first write `fpioa_waddr_o`=8'h00, `fpioa_data_o`=32'h00002007, `fpioa_sel_o`=4'hF. Exactly 40 writes follow START. `done_o` and `cpu_ready_o` rise on cycle 42.
- `DEF_IN` entries 2=5 and 3=6 -> the LOAD_IN write at 8'h80 carries 32'h06050000. The last write is at 8'hFC.
- During the load, `cpu_we_i`=1 at 8'h04 with data 32'h0000007F -> `fpioa_we_o` carries only loader writes. After ready, the held CPU write appears unchanged on the `fpioa_*` outputs for one cycle.
- In IDLE, `reload_i` pulse -> `busy_o`=1 and `done_o`=0 on the next cycle. 41 cycles later `done_o`=1 again, with the same write sequence as the boot load.
- `rst_n` low at load cycle 20 for 3 cycles -> all outputs at reset values. After release the sequence restarts at 8'h00, and `done_o` rises exactly 41 cycles after release.
- `reload_i` asserted in LOAD_IN -> ignored. Exactly one IDLE entry occurs, with no second sequence.

Source files
------------

// File: rtl/fpioa_cfg_seq.sv
// Boot-time FPIOA default pin-map loader; after the load it hands the FPIOA
// register port to the CPU bus, and re-applies the map on reload_i.
module fpioa_cfg_seq #(
    parameter logic [223:0] DEF_OT = '0,
    parameter logic [639:0] DEF_IN = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reload_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [7:0]  cpu_waddr_i,
    input  logic [31:0] cpu_data_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  cpu_raddr_i,
    input  logic        cpu_rd_i,
    output logic        cpu_ready_o,
    output logic [31:0] cpu_data_o,
    output logic [7:0]  fpioa_waddr_o,
    output logic [31:0] fpioa_data_o,
    output logic [3:0]  fpioa_sel_o,
    output logic        fpioa_we_o,
    output logic [7:0]  fpioa_raddr_o,
    output logic        fpioa_rd_o,
    input  logic [31:0] fpioa_data_i
);

    typedef enum logic [1:0] {
        START,
        LOAD_OT,
        LOAD_IN,
        IDLE
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic       loaded, loaded_nxt;

    logic [6:0] ot_tab [32];
    logic [4:0] in_tab [128];

    for (genvar k = 0; k < 32; k++) begin : g_ot
        assign ot_tab[k] = DEF_OT[7*k +: 7];
    end

    for (genvar k = 0; k < 128; k++) begin : g_in
        assign in_tab[k] = DEF_IN[5*k +: 5];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= START;
            cnt    <= '0;
            loaded <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            loaded <= loaded_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        loaded_nxt    = loaded;
        cpu_ready_o   = 1'b0;
        fpioa_waddr_o = '0;
        fpioa_data_o  = '0;
        fpioa_sel_o   = '0;
        fpioa_we_o    = 1'b0;
        fpioa_raddr_o = '0;
        fpioa_rd_o    = 1'b0;

        case (state)
            START: begin
                state_nxt = LOAD_OT;
                cnt_nxt   = '0;
            end

            // Each word packs four consecutive table entries, entry 4*cnt in byte 0.
            LOAD_OT: begin
                fpioa_we_o    = 1'b1;
                fpioa_sel_o   = '1;
                fpioa_waddr_o = {1'b0, cnt, 2'b00};
                fpioa_data_o  = {1'b0, ot_tab[{cnt[2:0], 2'd3}],
                                 1'b0, ot_tab[{cnt[2:0], 2'd2}],
                                 1'b0, ot_tab[{cnt[2:0], 2'd1}],
                                 1'b0, ot_tab[{cnt[2:0], 2'd0}]};
                if (cnt == 5'd7) begin
                    state_nxt = LOAD_IN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end

            LOAD_IN: begin
                fpioa_we_o    = 1'b1;
                fpioa_sel_o   = '1;
                fpioa_waddr_o = {1'b1, cnt, 2'b00};
                fpioa_data_o  = {3'b000, in_tab[{cnt, 2'd3}],
                                 3'b000, in_tab[{cnt, 2'd2}],
                                 3'b000, in_tab[{cnt, 2'd1}],
                                 3'b000, in_tab[{cnt, 2'd0}]};
                if (cnt == 5'd31) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    loaded_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end

            IDLE: begin
                cpu_ready_o   = 1'b1;
                fpioa_waddr_o = cpu_waddr_i;
                fpioa_data_o  = cpu_data_i;
                fpioa_sel_o   = cpu_sel_i;
                fpioa_we_o    = cpu_we_i;
                fpioa_raddr_o = cpu_raddr_i;
                fpioa_rd_o    = cpu_rd_i;
                if (reload_i) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end

            default: begin
                state_nxt = START;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy_o     = (state != IDLE);
    assign done_o     = (state == IDLE) && loaded;
    assign cpu_data_o = fpioa_data_i;

endmodule
